ps2_scancode_decoder: RTL
=========================

# ps2_scancode_decoder

Decodes the PS/2 set-2 scan-code byte stream produced by the keyboard receiver (`Keyboard`: `o_data`/`o_finish`) into key events. Handles the `E0` (extended), `F0` (break) and `E1` (pause) prefixes, suppresses typematic repeats, and maintains a held-key bitmap of the game's control keys. Sits between the PS/2 receiver and the game control logic.

## Interface
- `TIMEOUT_CYCLES`, default 50000: maximum idle `i_clk` cycles between bytes of one multi-byte sequence (1 ms at 50 MHz).
- `i_clk`  in  1  system clock, the same domain as the receiver.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  8  received byte; connects to the receiver's `o_data`.
- `i_valid`  in  1  byte-ready; connects to the receiver's `o_finish`. May be a one-cycle pulse or a multi-cycle level. Only the rising edge is used.
- `o_key`  out  8  scan code of the last event (prefixes stripped).
- `o_ext`  out  1  last event carried the `E0` prefix.
- `o_release`  out  1  last event was a break (`F0`).
- `o_event`  out  1  one-cycle strobe; `o_key`/`o_ext`/`o_release` valid.
- `o_repeat`  out  1  qualifies `o_event`: make for a key already reported made with no intervening break.
- `o_held`  out  8  held bitmap, bits [7:0] = up(E0 75), down(E0 72), left(E0 6B), right(E0 74), space(29), enter(5A), esc(76), P(4D).
- `o_err`  out  1  one-cycle strobe on a malformed sequence or a timeout.

## Operation
- Byte accept: `acc = i_valid & ~valid_q`, where `valid_q` is `i_valid` registered. Exactly one accept per rising edge of `i_valid`.
- FSM states: IDLE, E0, F0, E0F0, SKIP. Transitions on `acc`:
  - IDLE:
    - `E0` → E0.
    - `F0` → F0.
    - `E1` → SKIP, with `skip_cnt` = 7.
    - `00, AA, EE, FA, FC, FE, FF` (controller responses) are dropped; stay in IDLE.
    - Any other byte: emit make, ext = 0.
  - E0:
    - `F0` → E0F0.
    - `12` or `59` (fake shift) is dropped → IDLE.
    - `E0`, `E1` or a controller response: `o_err` → IDLE.
    - Any other byte: emit make, ext = 1 → IDLE.
  - F0:
    - Prefix byte or controller response: `o_err` → IDLE.
    - Any other byte: emit break, ext = 0 → IDLE.
  - E0F0:
    - `12` or `59` is dropped → IDLE.
    - Prefix byte or controller response: `o_err` → IDLE.
    - Any other byte: emit break, ext = 1 → IDLE.
  - SKIP: decrement `skip_cnt` per byte; the byte that brings it to 0 returns to IDLE. No event is emitted.
- Repeat tracking: a register `{last_ext, last_key, last_vld}`.
  - On a make matching the register with `last_vld` = 1: `o_repeat` = 1.
  - Otherwise `o_repeat` = 0 and the register loads the new make.
  - A break of the same key clears `last_vld`.
- Held bitmap: a make of a mapped key sets its bit; a break clears it. Unmapped keys and `ext` mismatches have no effect (for example, non-ext 75 does not set up).
- Timeout: a cycle counter runs while state ≠ IDLE and is cleared on every `acc`.
  - On reaching `TIMEOUT_CYCLES`: → IDLE, `o_err` = 1, partial sequence discarded, `skip_cnt` cleared.
  - The counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Timing
- Reset values: state IDLE; all outputs 0; `valid_q`, `skip_cnt`, the timeout counter and the repeat register are 0.
- Latency: `i_valid` first sampled high at edge N → `o_event`/`o_err` high in cycle N+1 for exactly one cycle.
- `o_key`, `o_ext`, `o_release`, `o_repeat` update with `o_event` and hold until the next event.
- `o_held` updates in the same cycle as `o_event`.
- `o_event` and `o_err` are never both high.
- Timeout and `acc` in the same cycle: the byte is processed in the current state, and the timeout is ignored.
- `i_valid` held high across many cycles yields one accept. It must drop for ≥ 1 cycle before the next byte.
- Reset mid-sequence, including SKIP: returns to IDLE, clears `o_held`, and emits no event.

## Test plan
- Bytes `1C`, `F0 1C`, gap 100 clk → two events:
  - `o_key` = 1C, `o_ext` = 0, `o_release` = 0.
  - `o_key` = 1C, `o_release` = 1.
  - `o_held` stays 00.
- `E0 75`, `E0 75`, `E0 F0 75` → three events:
  - `o_held[7]` 1 → 1 → 0.
  - `o_repeat` = 0, 1, 0.
  - `o_ext` = 1 on all three.
- `E1 14 77 E1 F0 14 F0 77` → no `o_event`, no `o_err`. A following `29` → make 29, with `o_held[3]` = 1.
- `E0 12 E0 7C` (print screen) → a single event, `o_key` = 7C with `o_ext` = 1. The fake shift is dropped.
- `F0` then silence for `TIMEOUT_CYCLES`:
  - `o_err` pulses once.
  - A following `5A` → make 5A, not a break, and `o_held[2]` = 1.
- `i_valid` held high for 5 cycles with `1C` → exactly one `o_event`. Assert `i_rst_n` = 0 after `E0` → state IDLE and `o_held` = 00. After release, a following `75` → make, with `o_ext` = 0.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0/E1 prefixes, flags typematic
// repeats, tracks held game keys and times out stalled multi-byte sequences.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic [7:0] o_key,
  output logic       o_ext,
  output logic       o_release,
  output logic       o_event,
  output logic       o_repeat,
  output logic [7:0] o_held,
  output logic       o_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_e;

  function automatic logic is_resp(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  function automatic logic [7:0] held_mask(input logic ext, input logic [7:0] key);
    case ({ext, key})
      9'h175:  return 8'h80;
      9'h172:  return 8'h40;
      9'h16B:  return 8'h20;
      9'h174:  return 8'h10;
      9'h029:  return 8'h08;
      9'h05A:  return 8'h04;
      9'h076:  return 8'h02;
      9'h04D:  return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic          valid_q;
  logic [2:0]    skip_q, skip_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    key_q, key_d, held_q, held_d, last_key_q, last_key_d;
  logic          ext_q, ext_d, rel_q, rel_d, rep_q, rep_d;
  logic          event_d, err_d, event_q, err_q;
  logic          last_ext_q, last_ext_d, last_vld_q, last_vld_d;
  logic          acc, emit, emit_ext, emit_rel, match;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    key_d      = key_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    rep_d      = rep_q;
    held_d     = held_q;
    last_key_d = last_key_q;
    last_ext_d = last_ext_q;
    last_vld_d = last_vld_q;
    event_d    = 1'b0;
    err_d      = 1'b0;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    acc        = i_valid & ~valid_q;

    if (acc) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (i_data == 8'hE0)      state_d = S_E0;
          else if (i_data == 8'hF0) state_d = S_F0;
          else if (i_data == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_resp(i_data)) emit = 1'b1;
        end
        S_E0: begin
          state_d = S_IDLE;
          if (i_data == 8'hF0) state_d = S_E0F0;
          else if (is_fake_shift(i_data)) ;
          else if (is_prefix(i_data) || is_resp(i_data)) err_d = 1'b1;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        S_F0: begin
          state_d = S_IDLE;
          if (is_prefix(i_data) || is_resp(i_data)) err_d = 1'b1;
          else begin
            emit     = 1'b1;
            emit_rel = 1'b1;
          end
        end
        S_E0F0: begin
          state_d = S_IDLE;
          if (is_fake_shift(i_data)) ;
          else if (is_prefix(i_data) || is_resp(i_data)) err_d = 1'b1;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
          end
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A byte arriving on the deadline cycle wins; only a true idle cycle times out.
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + CW'(1);
      end
    end

    match = last_vld_q && (last_ext_q == emit_ext) && (last_key_q == i_data);
    if (emit) begin
      event_d = 1'b1;
      key_d   = i_data;
      ext_d   = emit_ext;
      rel_d   = emit_rel;
      if (!emit_rel) begin
        rep_d  = match;
        held_d = held_q | held_mask(emit_ext, i_data);
        if (!match) begin
          last_key_d = i_data;
          last_ext_d = emit_ext;
          last_vld_d = 1'b1;
        end
      end else begin
        rep_d  = 1'b0;
        held_d = held_q & ~held_mask(emit_ext, i_data);
        if (match) last_vld_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      skip_q     <= '0;
      tmo_q      <= '0;
      key_q      <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      rep_q      <= 1'b0;
      held_q     <= '0;
      event_q    <= 1'b0;
      err_q      <= 1'b0;
      last_key_q <= '0;
      last_ext_q <= 1'b0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= i_valid;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      key_q      <= key_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      rep_q      <= rep_d;
      held_q     <= held_d;
      event_q    <= event_d;
      err_q      <= err_d;
      last_key_q <= last_key_d;
      last_ext_q <= last_ext_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign o_key     = key_q;
  assign o_ext     = ext_q;
  assign o_release = rel_q;
  assign o_repeat  = rep_q;
  assign o_held    = held_q;
  assign o_event   = event_q;
  assign o_err     = err_q;

endmodule
